// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that shares one sequential 8x8 multiplier between NUM_REQ requesters.
// Captures the winner's operands, runs the start/done handshake with a timeout, and returns the product.
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_dataa,
    input  logic [8*NUM_REQ-1:0]   req_datab,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [15:0]            rsp_product,
    output logic                   rsp_err,
    output logic                   mult_start,
    output logic [7:0]             mult_dataa,
    output logic [7:0]             mult_datab,
    input  logic                   mult_done,
    input  logic [15:0]            mult_product,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [7:0]    run_cnt;

    logic [PW-1:0] win_idx;
    logic [PW-1:0] cand;
    logic          win_found;
    int            j;

    assign dbg_state = state;

    // Handshake: req is a level held until its gnt pulse is seen; gnt and rsp_valid are
    // one-cycle pulses with no backpressure, so a response is never stalled.
    always_comb begin
        win_idx   = ptr;
        win_found = 1'b0;
        cand      = '0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            cand = PW'(j);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            owner       <= '0;
            run_cnt     <= '0;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_product <= '0;
            rsp_err     <= 1'b0;
            mult_start  <= 1'b0;
            mult_dataa  <= '0;
            mult_datab  <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        mult_dataa <= req_dataa[{win_idx, 3'b000} +: 8];
                        mult_datab <= req_datab[{win_idx, 3'b000} +: 8];
                        owner      <= win_idx;
                        gnt        <= ONE << win_idx;
                        mult_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    gnt        <= '0;
                    mult_start <= 1'b0;
                    run_cnt    <= '0;
                    state      <= S_RUN;
                end
                S_RUN: begin
                    // A done seen on the first RUN cycle may still belong to the previous operation.
                    if (mult_done && run_cnt != 8'd0) begin
                        rsp_product <= mult_product;
                        rsp_err     <= 1'b0;
                        rsp_valid   <= ONE << owner;
                        state       <= S_RESP;
                    end else if (run_cnt == CNT_LAST) begin
                        rsp_product <= '0;
                        rsp_err     <= 1'b1;
                        rsp_valid   <= ONE << owner;
                        state       <= S_RESP;
                    end else begin
                        run_cnt <= run_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    rsp_valid <= '0;
                    ptr       <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed + randomized bench for mult_share_arbiter with a multiplier model and a round-robin reference.
module tb_mult_share_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;

    logic             clk;
    logic             arst_n;
    logic [N-1:0]     req;
    logic [8*N-1:0]   req_dataa;
    logic [8*N-1:0]   req_datab;
    logic [N-1:0]     gnt;
    logic [N-1:0]     rsp_valid;
    logic [15:0]      rsp_product;
    logic             rsp_err;
    logic             mult_start;
    logic [7:0]       mult_dataa;
    logic [7:0]       mult_datab;
    logic             mult_done;
    logic [15:0]      mult_product;
    logic             busy;
    logic [1:0]       dbg_state;

    int total = 0;
    int bad   = 0;

    // reference-model state
    int         ptr_m = 0;
    logic [N-1:0] req_r = '0;
    logic [7:0] opa [N];
    logic [7:0] opb [N];

    // multiplier-model controls
    int         done_at = 0;
    bit         stale_mode = 0;
    int         k = -1;
    logic [7:0] ma, mb;

    mult_share_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .req          (req),
        .req_dataa    (req_dataa),
        .req_datab    (req_datab),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_product  (rsp_product),
        .rsp_err      (rsp_err),
        .mult_start   (mult_start),
        .mult_dataa   (mult_dataa),
        .mult_datab   (mult_datab),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequential multiplier: done is a level that stays high until the next start.
    // In stale mode done never drops and the first RUN cycle shows a bogus product.
    always @(negedge clk) begin
        if (!arst_n) begin
            k         = -1;
            mult_done = 1'b0;
        end else if (mult_start) begin
            k            = 0;
            ma           = mult_dataa;
            mb           = mult_datab;
            mult_done    = stale_mode;
            mult_product = stale_mode ? 16'hDEAD : 16'h0000;
        end else if (k >= 0) begin
            k            = k + 1;
            mult_done    = stale_mode || (done_at > 0 && k >= done_at);
            mult_product = (stale_mode && k == 1) ? 16'hDEAD : ({8'h00, ma} * {8'h00, mb});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req();
        req = req_r;
        for (int i = 0; i < N; i++) begin
            req_dataa[8*i +: 8] = opa[i];
            req_datab[8*i +: 8] = opb[i];
        end
    endtask

    // One complete operation: grant, run, response, return to idle.
    task automatic run_one(input int d_at, input bit stale, input bit drop, input bit rel_all);
        int          exp_w;
        int          exp_run;
        logic        exp_err;
        logic [15:0] exp_p;
        int          n;
        bit          got;
        exp_w = -1;
        for (int i = 0; i < N; i++) begin
            if (exp_w < 0 && req_r[(ptr_m + i) % N]) exp_w = (ptr_m + i) % N;
        end
        if (exp_w < 0) exp_w = 0;
        done_at    = d_at;
        stale_mode = stale;
        drive_req();

        n = 0; got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (gnt != '0) got = 1;
        end
        check("gnt_wait", 32'(got), 32'd1);
        if (!got) return;
        check("gnt", 32'(gnt), 32'(1 << exp_w));
        check("start", 32'(mult_start), 32'd1);
        check("dataa", 32'(mult_dataa), 32'(opa[exp_w]));
        check("datab", 32'(mult_datab), 32'(opb[exp_w]));
        check("busy_start", 32'(busy), 32'd1);
        if (drop) begin
            req_r[exp_w] = 1'b0;
            req = req_r;
        end

        if (stale || (d_at > 0 && d_at <= TO)) begin
            exp_run = stale ? 2 : ((d_at < 2) ? 2 : d_at);
            exp_err = 1'b0;
            exp_p   = 16'(int'(opa[exp_w]) * int'(opb[exp_w]));
        end else begin
            exp_run = TO;
            exp_err = 1'b1;
            exp_p   = 16'h0000;
        end

        n = 0; got = 0;
        while (!got && n < TO + 10) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                got = 1;
            end else begin
                n++;
                check("run_gnt", 32'(gnt), 32'd0);
                check("run_start", 32'(mult_start), 32'd0);
                check("run_dataa", 32'(mult_dataa), 32'(opa[exp_w]));
            end
        end
        check("rsp_wait", 32'(got), 32'd1);
        if (!got) return;
        check("run_len", 32'(n), 32'(exp_run));
        check("rsp_valid", 32'(rsp_valid), 32'(1 << exp_w));
        check("rsp_product", 32'(rsp_product), 32'(exp_p));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("resp_dataa", 32'(mult_dataa), 32'(opa[exp_w]));
        check("resp_datab", 32'(mult_datab), 32'(opb[exp_w]));
        check("busy_resp", 32'(busy), 32'd1);
        ptr_m = (exp_w + 1) % N;
        if (rel_all) begin
            req_r = '0;
            req   = '0;
        end

        @(negedge clk);
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("prod_hold", 32'(rsp_product), 32'(exp_p));
        check("err_hold", 32'(rsp_err), 32'(exp_err));
    endtask

    initial begin
        int n;
        bit got;
        arst_n       = 1'b0;
        req          = '0;
        req_dataa    = '0;
        req_datab    = '0;
        mult_done    = 1'b0;
        mult_product = '0;
        for (int i = 0; i < N; i++) begin
            opa[i] = 8'(10 + i);
            opb[i] = 8'(20 + 3 * i);
        end
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_start", 32'(mult_start), 32'd0);
        check("rst_product", 32'(rsp_product), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_dataa", 32'(mult_dataa), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        arst_n = 1'b1;
        @(negedge clk);

        // single request, done on the 5th RUN cycle
        opa[0] = 8'd100; opb[0] = 8'd200;
        req_r = 4'b0001;
        run_one(5, 0, 1, 0);

        // all four requesting: 0,1,2,3 then 0 before 3
        for (int i = 0; i < N; i++) begin
            opa[i] = 8'($urandom_range(0, 255));
            opb[i] = 8'($urandom_range(0, 255));
        end
        req_r = 4'b1111;
        for (int i = 0; i < N; i++) run_one($urandom_range(2, 7), 0, 1, 0);
        req_r = 4'b1001;
        run_one(3, 0, 1, 0);
        run_one(4, 0, 1, 0);

        // two requesters held continuously alternate
        req_r = 4'b0101;
        for (int i = 0; i < 4; i++) run_one($urandom_range(2, 5), 0, 0, i == 3);

        // no done at all: timeout after TO RUN cycles
        req_r = 4'b0010;
        run_one(0, 0, 1, 0);

        // done stuck high from before START
        opa[3] = 8'd255; opb[3] = 8'd255;
        req_r = 4'b1000;
        run_one(2, 0, 1, 0);
        req_r = 4'b1000;
        run_one(0, 1, 1, 0);
        opa[1] = 8'd0; opb[1] = 8'd77;
        req_r = 4'b0010;
        run_one(0, 1, 1, 0);

        // move pointer to 3, then reset in the middle of an operation
        req_r = 4'b0100;
        run_one(3, 0, 1, 0);
        req_r      = 4'b0010;
        done_at    = 0;
        stale_mode = 0;
        drive_req();
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (gnt != '0) got = 1;
        end
        check("rst_gnt_wait", 32'(got), 32'd1);
        check("rst_gnt_owner", 32'(gnt), 32'b0010);
        req_r = '0;
        req   = '0;
        repeat (3) @(negedge clk);
        arst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_start", 32'(mult_start), 32'd0);
        check("mid_rst_product", 32'(rsp_product), 32'd0);
        check("mid_rst_err", 32'(rsp_err), 32'd0);
        check("mid_rst_dataa", 32'(mult_dataa), 32'd0);
        check("mid_rst_datab", 32'(mult_datab), 32'd0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        ptr_m  = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_rsp", 32'(rsp_valid), 32'd0);
        end
        req_r = 4'b1010;
        run_one(3, 0, 1, 0);
        run_one(2, 0, 1, 0);

        // random mix of masks, done latencies, timeouts and stale done
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < N; i++) begin
                opa[i] = 8'($urandom_range(0, 255));
                opb[i] = 8'($urandom_range(0, 255));
            end
            req_r = req_r | 4'($urandom_range(1, 15));
            run_one($urandom_range(0, 17), $urandom_range(0, 5) == 0, 1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
